// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decode handoff and redirect/fault lines.
// The master modport is the fetch unit; the slave modport is memory, decode and execute together.
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc, fault,
        input  mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, fault,
        output mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads words over req/ack, hands them to decode
// over valid/ready and follows redirects, parking in FAULT on misaligned targets.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        pend_redir;
    logic [31:0] pend_pc;
    logic [31:0] ack_target;

    // A redirect arriving in the ack cycle is newer than any saved one.
    assign ack_target = bus.redirect_valid ? bus.redirect_pc : pend_pc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            instr_q    <= '0;
            instr_pc_q <= '0;
            pend_redir <= 1'b0;
            pend_pc    <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (bus.mem_ack) begin
                        if (bus.redirect_valid || pend_redir) begin
                            pend_redir <= 1'b0;
                            pc         <= ack_target;
                            state      <= (ack_target[1:0] != 2'b00) ? FAULT : REQ;
                        end else begin
                            instr_q    <= bus.mem_rdata;
                            instr_pc_q <= pc;
                            state      <= HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        pend_redir <= 1'b1;
                        pend_pc    <= bus.redirect_pc;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        pc    <= bus.redirect_pc;
                        state <= (bus.redirect_pc[1:0] != 2'b00) ? FAULT : REQ;
                    end else if (bus.instr_ready) begin
                        pc    <= pc + 32'd4;
                        state <= REQ;
                    end
                end
                FAULT: begin
                    if (bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00)) begin
                        pc    <= bus.redirect_pc;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req     = (state == REQ);
    assign bus.mem_addr    = pc;
    assign bus.instr_valid = (state == HOLD);
    assign bus.fault       = (state == FAULT);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: two instances (reset vector 0 and 0xFFFF_FFFC) checked
// every cycle against a transaction-level model of fetch/present/fault behaviour.
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0;
    logic rst_n1;
    fetch_unit_if if0 ();
    fetch_unit_if if1 ();

    fetch_unit #(.RESET_VECTOR(32'h0000_0000)) u_dut0 (.clk(clk), .reset_n(rst_n0), .bus(if0.master));
    fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut1 (.clk(clk), .reset_n(rst_n1), .bus(if1.master));

    typedef enum logic [1:0] {M_BOOT, M_FETCH, M_PRESENT, M_FAULT} mmode_t;

    mmode_t      m_mode  [2];
    logic [31:0] m_pc    [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_ipc   [2];
    logic        m_pend  [2];
    logic [31:0] m_ptgt  [2];
    logic [31:0] m_rv_val[2];

    logic        s_rst [2];
    logic        s_ack [2];
    logic        s_rdy [2];
    logic        s_rv  [2];
    logic [31:0] s_rpc [2];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference: what a fetch stage does this cycle given the inputs it saw.
    task automatic model_step(input int i);
        logic [31:0] t;
        if (!s_rst[i]) begin
            m_mode[i]  = M_BOOT;
            m_pc[i]    = m_rv_val[i];
            m_instr[i] = 32'd0;
            m_ipc[i]   = 32'd0;
            m_pend[i]  = 1'b0;
        end else begin
            case (m_mode[i])
                M_BOOT: m_mode[i] = M_FETCH;
                M_FETCH: begin
                    if (s_ack[i]) begin
                        if (s_rv[i] || m_pend[i]) begin
                            t = s_rv[i] ? s_rpc[i] : m_ptgt[i];
                            m_pend[i] = 1'b0;
                            m_pc[i]   = t;
                            m_mode[i] = (t % 4 != 0) ? M_FAULT : M_FETCH;
                        end else begin
                            m_instr[i] = mem_word(m_pc[i]);
                            m_ipc[i]   = m_pc[i];
                            m_mode[i]  = M_PRESENT;
                        end
                    end else if (s_rv[i]) begin
                        m_pend[i] = 1'b1;
                        m_ptgt[i] = s_rpc[i];
                    end
                end
                M_PRESENT: begin
                    if (s_rv[i]) begin
                        m_pc[i]   = s_rpc[i];
                        m_mode[i] = (s_rpc[i] % 4 != 0) ? M_FAULT : M_FETCH;
                    end else if (s_rdy[i]) begin
                        m_pc[i]   = m_pc[i] + 32'd4;
                        m_mode[i] = M_FETCH;
                    end
                end
                M_FAULT: begin
                    if (s_rv[i] && (s_rpc[i] % 4 == 0)) begin
                        m_pc[i]   = s_rpc[i];
                        m_mode[i] = M_FETCH;
                    end
                end
                default: m_mode[i] = M_BOOT;
            endcase
        end
    endtask

    task automatic check_inst(input int i);
        logic        req, vld, flt;
        logic [31:0] addr, ins, ipc;
        if (i == 0) begin
            req = if0.mem_req; addr = if0.mem_addr; vld = if0.instr_valid;
            flt = if0.fault;   ins  = if0.instr;    ipc = if0.instr_pc;
        end else begin
            req = if1.mem_req; addr = if1.mem_addr; vld = if1.instr_valid;
            flt = if1.fault;   ins  = if1.instr;    ipc = if1.instr_pc;
        end
        check_val($sformatf("u%0d.mem_req", i), {31'd0, req}, {31'd0, m_mode[i] == M_FETCH});
        if (m_mode[i] == M_FETCH)
            check_val($sformatf("u%0d.mem_addr", i), addr, m_pc[i]);
        check_val($sformatf("u%0d.instr_valid", i), {31'd0, vld}, {31'd0, m_mode[i] == M_PRESENT});
        check_val($sformatf("u%0d.fault", i), {31'd0, flt}, {31'd0, m_mode[i] == M_FAULT});
        check_val($sformatf("u%0d.instr", i), ins, m_instr[i]);
        check_val($sformatf("u%0d.instr_pc", i), ipc, m_ipc[i]);
    endtask

    task automatic pick_stim(input int i, input int cyc);
        logic [31:0] r;
        logic [7:0]  off;
        bit          directed;
        directed  = (cyc < 40);
        s_rst[i]  = (cyc < 3) ? 1'b0 : (directed ? 1'b1 : ($urandom_range(0, 59) != 0));
        s_ack[i]  = (m_mode[i] == M_FETCH) && (directed || ($urandom_range(0, 3) == 0));
        s_rdy[i]  = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
        s_rv[i]   = directed ? 1'b0 : ($urandom_range(0, 6) == 0);
        r   = $urandom;
        off = r[7:0];
        case ($urandom_range(0, 9))
            0:       s_rpc[i] = {r[31:2], (r[1:0] == 2'b00) ? 2'b10 : r[1:0]};
            1:       s_rpc[i] = r[8] ? 32'hFFFF_FFFC : 32'hFFFF_FFF8;
            default: s_rpc[i] = {22'd0, off, 2'b00};
        endcase
    endtask

    task automatic apply_stim();
        rst_n0 = s_rst[0]; if0.mem_ack = s_ack[0]; if0.instr_ready = s_rdy[0];
        if0.redirect_valid = s_rv[0]; if0.redirect_pc = s_rpc[0]; if0.mem_rdata = mem_word(m_pc[0]);
        rst_n1 = s_rst[1]; if1.mem_ack = s_ack[1]; if1.instr_ready = s_rdy[1];
        if1.redirect_valid = s_rv[1]; if1.redirect_pc = s_rpc[1]; if1.mem_rdata = mem_word(m_pc[1]);
    endtask

    initial begin
        m_rv_val[0] = 32'h0000_0000;
        m_rv_val[1] = 32'hFFFF_FFFC;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_BOOT; m_pc[i] = m_rv_val[i]; m_instr[i] = '0; m_ipc[i] = '0;
            m_pend[i] = 1'b0;   m_ptgt[i] = '0;
            s_rst[i]  = 1'b0;   s_ack[i] = 1'b0; s_rdy[i] = 1'b0; s_rv[i] = 1'b0; s_rpc[i] = '0;
        end
        apply_stim();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            check_inst(0);
            check_inst(1);
            pick_stim(0, cyc);
            pick_stim(1, cyc);
            apply_stim();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
